// File: rtl/vp_table_clear_ctrl.sv
// Clear sequencer for the last-value predictor tables: zeroes every entry
// after reset or flush, otherwise passes lookups and feedback straight through.
module vp_table_clear_ctrl #(
    parameter int P_STORAGE_SIZE = 2048,
    parameter int P_CONF_WIDTH   = 8,
    parameter int P_NUM_PRED     = 2
) (
    input  logic                                    clk_i,
    input  logic                                    rst_i,
    input  logic                                    flush_i,
    input  logic [P_NUM_PRED-1:0][31:1]             fw_pc_i,
    input  logic [P_NUM_PRED-1:0]                   fw_valid_i,
    output logic                                    fw_ready_o,
    output logic [P_NUM_PRED-1:0][31:1]             fw_pc_o,
    output logic [P_NUM_PRED-1:0]                   fw_valid_o,
    input  logic [P_NUM_PRED-1:0][31:1]             fb_pc_i,
    input  logic [P_NUM_PRED-1:0][31:0]             fb_actual_i,
    input  logic [P_NUM_PRED-1:0]                   fb_mispredict_i,
    input  logic [P_NUM_PRED-1:0][P_CONF_WIDTH:0]   fb_conf_i,
    input  logic [P_NUM_PRED-1:0]                   fb_valid_i,
    output logic                                    fb_ready_o,
    output logic [P_NUM_PRED-1:0][31:1]             fb_pc_o,
    output logic [P_NUM_PRED-1:0][31:0]             fb_actual_o,
    output logic [P_NUM_PRED-1:0]                   fb_mispredict_o,
    output logic [P_NUM_PRED-1:0][P_CONF_WIDTH:0]   fb_conf_o,
    output logic [P_NUM_PRED-1:0]                   fb_valid_o,
    output logic                                    busy_o,
    output logic                                    done_o
);

    localparam int P_INDEX_WIDTH = $clog2(P_STORAGE_SIZE);
    localparam int P_CLR_CYCLES  = P_STORAGE_SIZE / P_NUM_PRED;
    localparam int CNT_W = (P_CLR_CYCLES > 1) ? $clog2(P_CLR_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, CLEAR, DRAIN} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             busy_q;
    logic             rdy_q;
    logic             done_q;

    assign busy_o     = busy_q;
    assign fw_ready_o = rdy_q;
    assign fb_ready_o = rdy_q;
    assign done_o     = done_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= CLEAR;
            cnt    <= '0;
            busy_q <= 1'b1;
            rdy_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (flush_i) begin
                        state  <= CLEAR;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        rdy_q  <= 1'b0;
                    end
                end
                CLEAR: begin
                    if (flush_i) begin
                        cnt <= '0;
                    end else if (cnt == CNT_W'(P_CLR_CYCLES - 1)) begin
                        state <= DRAIN;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DRAIN: begin
                    if (flush_i) begin
                        state <= CLEAR;
                        cnt   <= '0;
                    end else begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                        rdy_q  <= 1'b1;
                        done_q <= 1'b1;
                    end
                end
                default: begin
                    state <= CLEAR;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Reset gates the data path directly so nothing leaks before the first edge
    always_comb begin
        fw_pc_o         = '0;
        fw_valid_o      = '0;
        fb_pc_o         = '0;
        fb_actual_o     = '0;
        fb_mispredict_o = '0;
        fb_conf_o       = '0;
        fb_valid_o      = '0;
        if (!rst_i) begin
            unique case (state)
                IDLE: begin
                    fw_pc_o         = fw_pc_i;
                    fw_valid_o      = fw_valid_i;
                    fb_pc_o         = fb_pc_i;
                    fb_actual_o     = fb_actual_i;
                    fb_mispredict_o = fb_mispredict_i;
                    fb_conf_o       = fb_conf_i;
                    fb_valid_o      = fb_valid_i;
                end
                CLEAR: begin
                    for (int p = 0; p < P_NUM_PRED; p++) begin
                        fb_valid_o[p]      = 1'b1;
                        fb_mispredict_o[p] = 1'b1;
                        fb_pc_o[p][P_INDEX_WIDTH:1] =
                            P_INDEX_WIDTH'(int'(cnt) * P_NUM_PRED + p);
                    end
                end
                DRAIN: begin
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vp_table_clear_ctrl.sv
// Randomized bench for vp_table_clear_ctrl: a two-lane N=16 instance and a
// single-lane N=8 instance share reset/flush and are checked against a phase model.
module tb_vp_table_clear_ctrl;

    localparam int N0 = 16;
    localparam int P0 = 2;
    localparam int C0 = N0 / P0;
    localparam int N1 = 8;
    localparam int P1 = 1;
    localparam int C1 = N1 / P1;
    localparam int CW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic flush;

    logic [P0-1:0][31:1]   fw_pc_i0, fw_pc_o0, fb_pc_i0, fb_pc_o0;
    logic [P0-1:0]         fw_valid_i0, fw_valid_o0, fb_valid_i0, fb_valid_o0;
    logic [P0-1:0][31:0]   fb_act_i0, fb_act_o0;
    logic [P0-1:0]         fb_mis_i0, fb_mis_o0;
    logic [P0-1:0][CW:0]   fb_conf_i0, fb_conf_o0;
    logic                  fw_rdy0, fb_rdy0, busy0, done0;

    logic [P1-1:0][31:1]   fw_pc_i1, fw_pc_o1, fb_pc_i1, fb_pc_o1;
    logic [P1-1:0]         fw_valid_i1, fw_valid_o1, fb_valid_i1, fb_valid_o1;
    logic [P1-1:0][31:0]   fb_act_i1, fb_act_o1;
    logic [P1-1:0]         fb_mis_i1, fb_mis_o1;
    logic [P1-1:0][CW:0]   fb_conf_i1, fb_conf_o1;
    logic                  fw_rdy1, fb_rdy1, busy1, done1;

    vp_table_clear_ctrl #(
        .P_STORAGE_SIZE(N0), .P_CONF_WIDTH(CW), .P_NUM_PRED(P0)
    ) dut0 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .fw_pc_i(fw_pc_i0), .fw_valid_i(fw_valid_i0), .fw_ready_o(fw_rdy0),
        .fw_pc_o(fw_pc_o0), .fw_valid_o(fw_valid_o0),
        .fb_pc_i(fb_pc_i0), .fb_actual_i(fb_act_i0),
        .fb_mispredict_i(fb_mis_i0), .fb_conf_i(fb_conf_i0),
        .fb_valid_i(fb_valid_i0), .fb_ready_o(fb_rdy0),
        .fb_pc_o(fb_pc_o0), .fb_actual_o(fb_act_o0),
        .fb_mispredict_o(fb_mis_o0), .fb_conf_o(fb_conf_o0),
        .fb_valid_o(fb_valid_o0), .busy_o(busy0), .done_o(done0)
    );

    vp_table_clear_ctrl #(
        .P_STORAGE_SIZE(N1), .P_CONF_WIDTH(CW), .P_NUM_PRED(P1)
    ) dut1 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .fw_pc_i(fw_pc_i1), .fw_valid_i(fw_valid_i1), .fw_ready_o(fw_rdy1),
        .fw_pc_o(fw_pc_o1), .fw_valid_o(fw_valid_o1),
        .fb_pc_i(fb_pc_i1), .fb_actual_i(fb_act_i1),
        .fb_mispredict_i(fb_mis_i1), .fb_conf_i(fb_conf_i1),
        .fb_valid_i(fb_valid_i1), .fb_ready_o(fb_rdy1),
        .fb_pc_o(fb_pc_o1), .fb_actual_o(fb_act_o1),
        .fb_mispredict_o(fb_mis_o1), .fb_conf_o(fb_conf_o1),
        .fb_valid_o(fb_valid_o1), .busy_o(busy1), .done_o(done1)
    );

    int checks = 0;
    int failures = 0;

    // pos: -1 idle, 0..C-1 clear step, C drain
    int pos0 = 0;
    int pos1 = 0;
    bit xdone0 = 1'b0;
    bit xdone1 = 1'b0;
    bit hold_fw = 1'b0;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge(input int c, inout int pos, output bit xd);
        xd = 1'b0;
        if (rst || flush) begin
            pos = 0;
        end else if (pos >= 0) begin
            pos++;
            if (pos > c) begin
                pos = -1;
                xd  = 1'b1;
            end
        end
    endtask

    task automatic rnd();
        logic [63:0] r;
        r = {$urandom(), $urandom()}; fw_pc_i0 = r[61:0];
        r = {$urandom(), $urandom()}; fb_pc_i0 = r[61:0];
        r = {$urandom(), $urandom()}; fb_act_i0 = r;
        r = {$urandom(), $urandom()}; fb_conf_i0 = r[17:0];
        r = {$urandom(), $urandom()};
        fw_valid_i0 = hold_fw ? 2'b11 : r[1:0];
        fb_valid_i0 = r[3:2];
        fb_mis_i0 = r[5:4];
        fw_valid_i1 = hold_fw ? 1'b1 : r[6];
        fb_valid_i1 = r[7];
        fb_mis_i1 = r[8];
        fb_conf_i1 = r[17:9];
        r = {$urandom(), $urandom()};
        fw_pc_i1 = r[30:0];
        fb_pc_i1 = r[61:31];
        fb_act_i1 = $urandom();
    endtask

    task automatic check0();
        logic [P0-1:0][31:1] epc;
        if (rst) begin
            chk("rst_fbv0", fb_valid_o0, 0);
            chk("rst_fwv0", fw_valid_o0, 0);
            chk("rst_rdy0", {fw_rdy0, fb_rdy0}, 0);
            chk("rst_busy0", busy0, 1);
            chk("rst_done0", done0, 0);
            chk("rst_pc0", {fw_pc_o0, fb_pc_o0}, 0);
            chk("rst_dat0", {fb_act_o0, fb_conf_o0, fb_mis_o0}, 0);
        end else if (pos0 < 0) begin
            chk("idle_rdy0", {fw_rdy0, fb_rdy0, busy0}, 3'b110);
            chk("idle_done0", done0, xdone0);
            chk("idle_fw0", {fw_pc_o0, fw_valid_o0}, {fw_pc_i0, fw_valid_i0});
            chk("idle_fbpc0", {fb_pc_o0, fb_valid_o0}, {fb_pc_i0, fb_valid_i0});
            chk("idle_fbd0", {fb_act_o0, fb_conf_o0, fb_mis_o0},
                {fb_act_i0, fb_conf_i0, fb_mis_i0});
        end else begin
            chk("busy_st0", {fw_rdy0, fb_rdy0, busy0, done0}, 4'b0010);
            chk("busy_fwv0", fw_valid_o0, 0);
            if (pos0 < C0) begin
                for (int p = 0; p < P0; p++) epc[p] = 31'(pos0 * P0 + p);
                chk("clr_fbv0", fb_valid_o0, 2'b11);
                chk("clr_pc0", fb_pc_o0, epc);
                chk("clr_dat0", {fb_act_o0, fb_conf_o0, fb_mis_o0},
                    {64'd0, 18'd0, 2'b11});
            end else begin
                chk("drn_fbv0", fb_valid_o0, 0);
            end
        end
    endtask

    task automatic check1();
        if (rst) begin
            chk("rst_v1", {fb_valid_o1, fw_valid_o1}, 0);
            chk("rst_st1", {fw_rdy1, fb_rdy1, busy1, done1}, 4'b0010);
        end else if (pos1 < 0) begin
            chk("idle_st1", {fw_rdy1, fb_rdy1, busy1, done1},
                {3'b110, xdone1});
            chk("idle_pt1", {fw_pc_o1, fw_valid_o1, fb_pc_o1, fb_valid_o1,
                             fb_act_o1, fb_conf_o1, fb_mis_o1},
                {fw_pc_i1, fw_valid_i1, fb_pc_i1, fb_valid_i1,
                 fb_act_i1, fb_conf_i1, fb_mis_i1});
        end else begin
            chk("busy_st1", {fw_rdy1, fb_rdy1, busy1, done1, fw_valid_o1},
                5'b00100);
            if (pos1 < C1) begin
                chk("clr_1", {fb_valid_o1, fb_pc_o1, fb_mis_o1, fb_conf_o1,
                              fb_act_o1},
                    {1'b1, 31'(pos1), 1'b1, 9'd0, 32'd0});
            end else begin
                chk("drn_1", fb_valid_o1, 0);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge(C0, pos0, xdone0);
        model_edge(C1, pos1, xdone1);
        @(negedge clk);
        check0();
        check1();
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        rnd();
        repeat (3) begin rnd(); step(); end
        rst = 1'b0;
        repeat (C0 + 3) begin rnd(); step(); end

        // directed idle pass-through
        rnd();
        fb_pc_i0[0] = 31'h20;
        fb_act_i0[0] = 32'hDEADBEEF;
        fb_valid_i0 = 2'b01;
        step();
        chk("dir_pc", fb_pc_o0[0], 31'h20);
        chk("dir_act", fb_act_o0[0], 32'hDEADBEEF);

        // flush restart at cnt 5
        flush = 1'b1; rnd(); step(); flush = 1'b0;
        repeat (5) begin rnd(); step(); end
        chk("pos5", pos0, 5);
        flush = 1'b1; rnd(); step(); flush = 1'b0;
        repeat (C0 + 3) begin rnd(); step(); end

        // reset mid-clear at cnt 3
        flush = 1'b1; rnd(); step(); flush = 1'b0;
        repeat (3) begin rnd(); step(); end
        rst = 1'b1; rnd(); step(); rst = 1'b0;
        repeat (C0 + 3) begin rnd(); step(); end

        // back-pressure through a flush
        hold_fw = 1'b1;
        flush = 1'b1; rnd(); step(); flush = 1'b0;
        repeat (C0 + 4) begin rnd(); step(); end
        hold_fw = 1'b0;

        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            flush = ($urandom_range(0, 59) == 0);
            hold_fw = ($urandom_range(0, 3) == 0);
            rnd();
            step();
        end
        rst = 1'b0;
        flush = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
